spi_cfg_rx: RTL
===============

Name: spi_cfg_rx

Overview:
- Framed SPI-slave receiver (mode 0) between the MCU SPI pins and the routing outputs (gpio_bin/gpio_fbin).
- Oversamples spi_clk/spi_ss/spi_mosi in the clk domain and assembles MSB-first frames.
- Commits a frame to cfg_out only when spi_ss deasserts after exactly WIDTH bits.
- Shifts out the previously committed configuration on spi_miso for MCU readback.

Parameters:
WIDTH, 16, frame and configuration width in bits (>=2)
SYNC_STAGES, 2, synchronizer flops per SPI input (>=2)

Ports:
clk  input  1  main clock; must be >= 4x spi_clk frequency
nreset  input  1  asynchronous active-low reset
spi_clk  input  1  SPI clock, idle low (mode 0)
spi_ss  input  1  SPI slave select, active low
spi_mosi  input  1  SPI data in, MSB first
spi_miso  output  1  SPI data out, MSB first
cfg_out  output  WIDTH  committed configuration word
cfg_valid  output  1  one-clk pulse in the cycle cfg_out updates
frame_err  output  1  one-clk pulse on a rejected frame

Behaviour:
- Interface: one clock (clk); reset nreset is asynchronous, active-low.
- Reset values: cfg_out=0, cfg_valid=0, frame_err=0, spi_miso=0, FSM=IDLE, bit counter=0, rx/tx shift registers=0, synchronizer flops and previous-value flops=1 for ss and 0 for clk/mosi.
- Synchronization: each input passes through SYNC_STAGES flops. Edges are detected from the synced value vs. a one-cycle-delayed copy. Pin-to-action latency is SYNC_STAGES+1 clk edges.
- FSM states:
  - IDLE: wait for ss fall (synced 1->0).
  - ARMED: entered from reset only, if synced ss is low. Wait for ss high, then go to IDLE. A frame in progress at reset release is never captured.
  - ACTIVE: on ss fall from IDLE, enter ACTIVE, clear the counter, load tx shift reg with cfg_out.
  - COMMIT: single cycle, then back to IDLE.
- ACTIVE, spi_clk rise: rx <= {rx[WIDTH-2:0], synced mosi}; counter increments and saturates at WIDTH+1.
- ACTIVE, spi_clk fall: tx <= {tx[WIDTH-2:0], 0}.
- ACTIVE, ss rise: go to COMMIT.
- COMMIT:
  - If counter==WIDTH: cfg_out <= rx and cfg_valid=1.
  - Otherwise: frame_err=1 and cfg_out unchanged. This covers both short and long (counter>WIDTH) frames.
- spi_miso = tx[WIDTH-1] while in ACTIVE, else 0.
  - MSB is valid SYNC_STAGES+2 clks after the ss pin falls.
  - The master must wait at least that long before the first spi_clk rise.
- Simultaneous events:
  - An ss rise detected in the same cycle as a spi_clk edge takes precedence; that clk edge is discarded.
  - spi_clk edges outside ACTIVE are ignored.
  - An ss fall in COMMIT is not lost: COMMIT goes directly to ACTIVE with the normal ACTIVE entry actions. The tx load uses the pre-commit cfg_out.
- Zero-bit frame (ss low then high, no clocks): counter=0, so frame_err pulses.
- Reset mid-frame: all state returns to reset values immediately. cfg_valid and frame_err never pulse for the interrupted frame.
- cfg_valid and frame_err are never high in the same cycle and are never high for more than one cycle.

Test Plan:
- Reset, then ss low, 16 clocks shifting 0xA5C3, ss high -> cfg_valid pulses exactly once; cfg_out=0xA5C3 within SYNC_STAGES+2 clks of the ss rise; frame_err stays 0.
- Second frame writing 0x0F0F after 0xA5C3 -> spi_miso sampled on spi_clk rises reads 0xA5C3 (the first bit is valid before the first rise); cfg_out becomes 0x0F0F.
- Frame of 15 bits (0x7FFF), then a frame of 17 bits -> frame_err pulses once per frame; cfg_out keeps its prior value (0x0F0F); cfg_valid stays 0.
- ss toggled with no spi_clk edges, and spi_clk toggled 8 times with ss high -> frame_err pulses for the empty frame; the ss-high clocks produce no effect; cfg_out is unchanged.
- nreset asserted after 8 bits of a frame and released while ss is still low, then 8 more clocks and ss high -> cfg_out=0 immediately on reset; no cfg_valid or frame_err pulse; the next full frame 0x1234 commits normally.
- Back-to-back frames with ss high for exactly 1 synced clk between them (ss fall lands in COMMIT), writing 0x1111 then 0x2222 -> both commit in order; the second frame's readback is 0x0000, the pre-commit value.

Source files
------------

// File: rtl/spi_cfg_rx_if.sv
// SPI pin bundle plus the committed-configuration outputs of the framed SPI receiver.
// The slave modport is the receiver; the master modport is the MCU/test side.
interface spi_cfg_rx_if #(
  parameter int unsigned WIDTH = 16
);
  logic             spi_clk;
  logic             spi_ss;
  logic             spi_mosi;
  logic             spi_miso;
  logic [WIDTH-1:0] cfg_out;
  logic             cfg_valid;
  logic             frame_err;

  modport slave (
    input  spi_clk,
    input  spi_ss,
    input  spi_mosi,
    output spi_miso,
    output cfg_out,
    output cfg_valid,
    output frame_err
  );

  modport master (
    output spi_clk,
    output spi_ss,
    output spi_mosi,
    input  spi_miso,
    input  cfg_out,
    input  cfg_valid,
    input  frame_err
  );
endinterface

// File: rtl/spi_cfg_rx.sv
// Oversampled mode-0 SPI slave: assembles MSB-first frames, commits exactly-WIDTH-bit frames
// to cfg_out on slave-select release and shifts the previous configuration back on spi_miso.
module spi_cfg_rx #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          nreset,
  spi_cfg_rx_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {StIdle, StArmed, StActive, StCommit} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, clk_sync_q, mosi_sync_q;
  logic                   ss_prev_q, clk_prev_q;
  logic [SYNC_STAGES:0]   boot_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]       rx_q, rx_d, tx_q, tx_d, cfg_q, cfg_d;
  logic                   valid_q, valid_d, err_q, err_d;

  logic ss_s, clk_s, mosi_s;
  logic ss_fall, ss_rise, clk_rise, clk_fall, boot;

  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ss_fall  = ss_prev_q & ~ss_s;
  assign ss_rise  = ~ss_prev_q & ss_s;
  assign clk_rise = ~clk_prev_q & clk_s;
  assign clk_fall = clk_prev_q & ~clk_s;
  // Held high until the synchronizers reflect the real pins, so a frame already in
  // progress at reset release is parked in StArmed instead of looking like a new ss fall.
  assign boot     = boot_q[SYNC_STAGES];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ss_sync_q   <= '1;
      clk_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_prev_q   <= 1'b1;
      clk_prev_q  <= 1'b0;
      boot_q      <= '1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cfg_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.spi_ss};
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
      ss_prev_q   <= ss_s;
      clk_prev_q  <= clk_s;
      boot_q      <= {boot_q[SYNC_STAGES-1:0], 1'b0};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cfg_q       <= cfg_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    cfg_d   = cfg_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (boot) begin
          if (!ss_s) state_d = StArmed;
        end else if (ss_fall) begin
          state_d = StActive;
          cnt_d   = '0;
          tx_d    = cfg_q;
        end
      end
      StArmed: begin
        if (ss_s) state_d = StIdle;
      end
      StActive: begin
        // ss release wins over a coincident spi_clk edge
        if (ss_rise) begin
          state_d = StCommit;
        end else if (clk_rise) begin
          rx_d = {rx_q[WIDTH-2:0], mosi_s};
          if (cnt_q != CntW'(WIDTH + 1)) cnt_d = cnt_q + 1'b1;
        end else if (clk_fall) begin
          tx_d = {tx_q[WIDTH-2:0], 1'b0};
        end
      end
      StCommit: begin
        if (cnt_q == CntW'(WIDTH)) begin
          cfg_d   = rx_q;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        // A new frame starting during commit reads back the pre-commit configuration
        if (ss_fall) begin
          state_d = StActive;
          cnt_d   = '0;
          tx_d    = cfg_q;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.spi_miso  = (state_q == StActive) ? tx_q[WIDTH-1] : 1'b0;
  assign bus.cfg_out   = cfg_q;
  assign bus.cfg_valid = valid_q;
  assign bus.frame_err = err_q;

endmodule
